// File: rtl/fifo_reader_tx.sv
// fifo_reader_tx
// Consumer end of a FIFO: pops one word at a time and sends it as an
// asynchronous serial frame: start bit (0), WIDTH data bits LSB first,
// optional even-parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//
// Optional feature: define FIFO_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     synchronous reset, active-low
//   en_i      permit starting new frames
//   pnding_i  FIFO has data available
//   data_i    FIFO head word, valid while pnding_i=1
//   pop_o     pop strobe to FIFO (combinational), one cycle per word
//   tx_o      serial line, idle high (registered)
//   busy_o    frame in progress (registered, aligned with tx_o)
//   done_o    one-cycle pulse in the final cycle of the stop bit
module fifo_reader_tx #(
    parameter int WIDTH        = 32,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             pnding_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             pop_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(WIDTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

`ifdef FIFO_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state, state_nxt;
    logic [BAUD_W-1:0]  baud_cnt, baud_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [WIDTH-1:0]   shreg, shreg_nxt;
    logic               tx_nxt;
    logic               busy_nxt;
    logic               done_nxt;

`ifdef FIFO_TX_PARITY_EN
    // Parity is taken from the word as popped, since the shift register
    // is consumed while the data bits go out.
    logic               parity_bit;
`endif

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        pop_o     = (state == IDLE) & en_i & pnding_i & rst_i;

        case (state)
            IDLE: begin
                if (pop_o) begin
                    state_nxt = START;
                    shreg_nxt = data_i;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    shreg_nxt = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt = '0;
`ifdef FIFO_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: begin
                if (baud_cnt == BAUD_LAST) begin
                    state_nxt = STOP;
                    baud_nxt  = '0;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
`endif
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    state_nxt = IDLE;
                    baud_nxt  = '0;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered from the next-state values so that they
        // line up with the state they describe.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
`ifdef FIFO_TX_PARITY_EN
            PARITY:  tx_nxt = parity_bit;
`endif
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == STOP) && (baud_nxt == BAUD_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            tx_o     <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
            tx_o     <= tx_nxt;
            busy_o   <= busy_nxt;
            done_o   <= done_nxt;
        end
    end

`ifdef FIFO_TX_PARITY_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            parity_bit <= 1'b0;
        end else if (pop_o) begin
            parity_bit <= ^data_i;
        end
    end
`endif

endmodule

// File: doc/fifo_reader_tx.md
Name: fifo_reader_tx

Overview:
- Consumer end of the FIFO interface: drains words from the FIFO output side and transmits each one as an asynchronous serial frame.
- Frame format: start bit, WIDTH data bits LSB first, optional parity bit, stop bit.
- Connects directly to a FIFO's pnding_o/data_o/pop_i and sits between the buffered datapath and the serial line.

Parameters:
- WIDTH, 32, data word width; matches the FIFO WIDTH.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal values ≥1.

Ports:
- clk_i  input  1  system clock, rising edge
- rst_i  input  1  reset, synchronous, active-low
- en_i  input  1  permit starting new frames
- pnding_i  input  1  FIFO has data available
- data_i  input  WIDTH  FIFO head word, valid while pnding_i=1
- pop_o  output  1  pop strobe to FIFO, one cycle per word
- tx_o  output  1  serial line, idle high
- busy_o  output  1  frame in progress
- done_o  output  1  one-cycle pulse at end of each frame

Behaviour:
- Clock and reset: single clock domain. All state updates on the rising edge of clk_i. Reset is taken when rst_i=0 at a clock edge.
- Reset values: state=IDLE, tx_o=1, busy_o=0, done_o=0, pop_o=0, counters=0, shift register=0.
- pop_o is combinational: (state==IDLE) & en_i & pnding_i & rst_i. Never high in any other state.
- On the edge where pop_o=1:
  - data_i is latched into the shift register.
  - state goes to START.
  - Exactly one pop per frame.
- States:
  - IDLE: tx_o=1, busy_o=0.
  - START: tx_o=0 for CLKS_PER_BIT cycles.
  - DATA: shift register bit 0 on tx_o. Shift right every CLKS_PER_BIT cycles. Bit counter 0..WIDTH-1. After WIDTH bits, go to PARITY if enabled, else STOP.
  - PARITY: present only with the macro; see Optional Feature.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then go to IDLE.
- tx_o is registered.
  - Pop at cycle T → tx_o=0 during cycles T+1 .. T+CLKS_PER_BIT.
  - Data bit k occupies cycles T+1+(k+1)*CLKS_PER_BIT onward.
- busy_o=1 in every non-IDLE state, registered and aligned with tx_o.
- done_o=1 only in the final cycle of STOP.
- Frame length F = (WIDTH+2)*CLKS_PER_BIT cycles, or (WIDTH+3)*CLKS_PER_BIT with parity.
  - Back-to-back words: exactly one IDLE cycle between frames.
  - Pop period is F+1 cycles.
- Counter widths:
  - Baud counter: $clog2(CLKS_PER_BIT) bits, minimum 1 bit.
  - Bit counter: $clog2(WIDTH)+1 bits.
  - Both wrap to 0 at bit/state boundaries. No free-running wrap.
- Boundary conditions:
  - en_i dropped mid-frame: current frame completes normally; no further pop.
  - en_i=1 with pnding_i=0: stay in IDLE; pop_o=0.
  - Changes on pnding_i/data_i outside IDLE: ignored.
  - Reset mid-frame: on the next edge tx_o=1, state=IDLE, no done_o pulse. A partial frame is abandoned and the popped word is lost.
  - rst_i=0 with pnding_i=1: pop_o=0.
  - CLKS_PER_BIT=1: every state lasts one cycle per bit; no stall.

Optional Feature:
- Macro: FIFO_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx_o = XOR of the latched word (even parity) for CLKS_PER_BIT cycles.
  - F gains CLKS_PER_BIT cycles.
- Undefined:
  - No PARITY state, no parity logic synthesized.
  - DATA goes directly to STOP.

Test Plan:
- Test 1, single word, WIDTH=8, CLKS_PER_BIT=4, no macro.
  - Stimulus: pnding_i=1 for one word, data_i=8'hA5, en_i=1, pop at cycle 10.
  - Required response: pop_o=1 only at cycle 10. tx_o=0 for cycles 11-14. Then bits 1,0,1,0,0,1,0,1 at 4 cycles each. Stop bit high for cycles 47-50. done_o=1 at cycle 50 only. busy_o=1 for cycles 11-50.
- Test 2, back-to-back:
  - Stimulus: FIFO holds 8'h01 and 8'hFF, pnding_i held high.
  - Required response: pops at T and T+41. Frame period 41 cycles. Second frame data bits all 1.
- Test 3, en_i gating:
  - Stimulus: en_i dropped during DATA of frame 1 with pnding_i=1.
  - Required response: frame 1 completes with done_o pulse; no second pop. Raising en_i again gives a pop the next cycle.
- Test 4, reset mid-frame:
  - Stimulus: rst_i=0 for one cycle during data bit 3.
  - Required response: next edge tx_o=1, busy_o=0, done_o never pulses. With pnding_i=1 and rst_i=1, pop at the following cycle.
- Test 5, FIFO_TX_PARITY_EN defined:
  - Stimulus: data_i=8'h07.
  - Required response: parity bit=1 for 4 cycles before stop. F=44. Repeat with 8'h03: parity bit=0.
- Test 6, CLKS_PER_BIT=1, WIDTH=32:
  - Stimulus: data_i=32'h8000_0001.
  - Required response: tx_o sequence 0,1,0×30,1,1. done_o exactly 34 cycles after pop.
